// File: rtl/tt_uart_pkg.sv
// Shared types and helpers for the Tiny Tapeout UART transmit/receive paths.
package tt_uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Even parity of the byte, inverted when odd parity is selected.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/tt_uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_tick_c on the last count.
module tt_uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_tick_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        bit_tick_c = 1'b0;
        cnt_d      = cnt_q + CNT_W'(1);
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            bit_tick_c = 1'b1;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_uart_tx.sv
// UART transmitter with a one-entry holding register; 8N1 or 8E1/8O1, LSB first.
module tt_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);
    localparam logic             PAR_ON    = (PARITY_EN != 0);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 par_q, par_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;

    logic                 accept_c;
    logic                 load_c;
    logic [DATA_BITS-1:0] load_src_c;
    logic                 bit_tick_c;
    logic                 baud_clr_c;

    // Counter is parked at zero in IDLE so the start bit gets a full period.
    assign baud_clr_c = (state_q == IDLE);

    tt_uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (baud_clr_c),
        .bit_tick_c(bit_tick_c)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_d       = par_q;
        idx_d       = idx_q;
        load_c      = 1'b0;
        accept_c    = tx_valid & ready_q & ena;
        load_src_c  = hold_full_q ? hold_q : tx_data;

        unique case (state_q)
            IDLE: begin
                if (accept_c || hold_full_q) begin
                    state_d = START;
                    load_c  = 1'b1;
                end
            end
            START: begin
                if (bit_tick_c) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_tick_c) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_DATA) begin
                        state_d = PAR_ON ? PARITY : STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick_c) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (bit_tick_c) begin
                    if (idx_q == LAST_STOP) begin
                        idx_d = '0;
                        if (hold_full_q) begin
                            state_d = START;
                            load_c  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An accept while a frame is running parks the byte in the holding register.
        if (accept_c && (state_q != IDLE)) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
        if (load_c) begin
            shift_d = load_src_c;
            par_d   = parity_of(load_src_c, ODD);
            if (hold_full_q) begin
                hold_full_d = 1'b0;
            end
        end

        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase

        busy_d  = (state_d != IDLE) | hold_full_d;
        ready_d = ena & ~hold_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            idx_q       <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            idx_q       <= idx_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign tx_ready = ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_tt_uart_tx.sv
// Scoreboarded bench for tt_uart_tx: four parameterisations, directed frames, serial-line monitors.
module tb_tt_uart_tx;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a   [4];
    logic       ena_a   [4];
    logic       valid_a [4];
    logic [7:0] data_a  [4];
    logic       rdy_w   [4];
    logic       tx_w    [4];
    logic       busy_w  [4];

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    tt_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_a[0]), .ena(ena_a[0]), .tx_data(data_a[0]), .tx_valid(valid_a[0]),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    tt_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_a[1]), .ena(ena_a[1]), .tx_data(data_a[1]), .tx_valid(valid_a[1]),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    tt_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_a[2]), .ena(ena_a[2]), .tx_data(data_a[2]), .tx_valid(valid_a[2]),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
    tt_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_a[3]), .ena(ena_a[3]), .tx_data(data_a[3]), .tx_valid(valid_a[3]),
        .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a byte, wait for the handshake, return #1 after the accept edge.
    task automatic send(input int i, input logic [7:0] d, input logic p);
        int n;
        n = 0;
        @(negedge clk);
        valid_a[i] = 1'b1;
        data_a[i]  = d;
        while (!(rdy_w[i] === 1'b1 && ena_a[i] === 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout inst%0d: tx_ready stayed %b, expected 1", i, rdy_w[i]);
            valid_a[i] = 1'b0;
            return;
        end
        exp_q.push_back('{i, d, p});
        @(posedge clk);
        #1 valid_a[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input string tag);
        int n;
        n = 0;
        while (busy_w[i] !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy_w[i] !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_idle_timeout: busy got %b expected 0", tag, busy_w[i]);
        end
    endtask

    // Cycle-exact line check from cycle 1 after the accept edge through the first idle cycle.
    task automatic check_frame(input int i, input logic [7:0] d, input int cpb, input int pe,
                               input logic par, input int nstop, input string tag);
        int   total;
        int   bad;
        int   b;
        logic exp_tx;
        total = cpb * (9 + pe + nstop);
        bad   = 0;
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            b = (k - 1) / cpb;
            if (k > total)             exp_tx = 1'b1;
            else if (b == 0)           exp_tx = 1'b0;
            else if (b <= 8)           exp_tx = d[b-1];
            else if (b == 9 && pe != 0) exp_tx = par;
            else                       exp_tx = 1'b1;
            if (tx_w[i] !== exp_tx) bad++;
            if (k == total) chk1({tag, "_busy_last"}, busy_w[i], 1'b1);
        end
        chk1({tag, "_busy_end"}, busy_w[i], 1'b0);
        chk8({tag, "_tx_bad_cycles"}, 8'(bad), 8'd0);
    endtask

    // Decode frames off the serial line and compare against the scoreboard queue.
    task automatic monitor(input int i, input int cpb, input int pe, input int nstop);
        logic [7:0] d;
        logic       p;
        logic       first;
        logic       framing_ok;
        logic       abort;
        exp_t       e;
        int         nbits;
        nbits = 9 + pe + nstop;
        forever begin
            @(negedge clk);
            if (rst_a[i] === 1'b1 && tx_w[i] === 1'b0) begin
                d = '0;
                p = 1'b0;
                framing_ok = 1'b1;
                abort = 1'b0;
                for (int b = 0; b < nbits; b++) begin
                    first = tx_w[i];
                    for (int c = 1; c < cpb; c++) begin
                        @(negedge clk);
                        if (rst_a[i] !== 1'b1) abort = 1'b1;
                        else if (tx_w[i] !== first) framing_ok = 1'b0;
                    end
                    if (abort) break;
                    if (b >= 1 && b <= 8)        d[b-1] = first;
                    else if (b == 9 && pe != 0)  p = first;
                    else if (b > 0 && first !== 1'b1) framing_ok = 1'b0;
                    if (b + 1 < nbits) begin
                        @(negedge clk);
                        if (rst_a[i] !== 1'b1) begin
                            abort = 1'b1;
                            break;
                        end
                    end
                end
                if (abort) begin
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                end else if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mon%0d_unexpected_frame: got data %h, expected no frame", i, d);
                end else begin
                    e = exp_q.pop_front();
                    chk8($sformatf("mon%0d_inst", i), 8'(i), 8'(e.inst));
                    chk8($sformatf("mon%0d_data", i), d, e.data);
                    if (pe != 0) chk1($sformatf("mon%0d_parity", i), p, e.par);
                    chk1($sformatf("mon%0d_framing", i), framing_ok, 1'b1);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic rdy_seen;
        logic bad_seen;
        for (int i = 0; i < 4; i++) begin
            rst_a[i]   = 1'b0;
            ena_a[i]   = 1'b1;
            valid_a[i] = 1'b0;
            data_a[i]  = 8'h00;
        end

        fork
            monitor(0, 4, 0, 1);
            monitor(1, 4, 1, 1);
            monitor(2, 4, 1, 1);
            monitor(3, 2, 0, 2);
        join_none

        // Reset values and first enabled edge.
        cyc(2);
        chk1("rst_tx", tx_w[0], 1'b1);
        chk1("rst_ready", rdy_w[0], 1'b0);
        chk1("rst_busy", busy_w[0], 1'b0);
        for (int i = 0; i < 4; i++) rst_a[i] = 1'b1;
        @(negedge clk);
        chk1("ready_after_rst", rdy_w[0], 1'b1);

        // 8N1, CLKS_PER_BIT=4: 0xA5 in 40 cycles.
        send(0, 8'hA5, 1'b0);
        check_frame(0, 8'hA5, 4, 0, 1'b0, 1, "t1_a5");

        // Parity: even then odd.
        send(1, 8'hA5, 1'b0);
        check_frame(1, 8'hA5, 4, 1, 1'b0, 1, "t2_even_a5");
        send(1, 8'h07, 1'b1);
        check_frame(1, 8'h07, 4, 1, 1'b1, 1, "t2_even_07");
        send(2, 8'hA5, 1'b1);
        check_frame(2, 8'hA5, 4, 1, 1'b1, 1, "t2_odd_a5");
        send(2, 8'h07, 1'b0);
        check_frame(2, 8'h07, 4, 1, 1'b0, 1, "t2_odd_07");

        // Back-to-back with tx_valid held high.
        @(negedge clk);
        chk1("t3_ready_pre", rdy_w[0], 1'b1);
        valid_a[0] = 1'b1;
        data_a[0]  = 8'h55;
        exp_q.push_back('{0, 8'h55, 1'b0});
        @(posedge clk);
        #1 data_a[0] = 8'h0F;
        exp_q.push_back('{0, 8'h0F, 1'b0});
        @(negedge clk);
        chk1("t3_ready_c1", rdy_w[0], 1'b1);
        @(posedge clk);
        #1 valid_a[0] = 1'b0;
        @(negedge clk);
        chk1("t3_ready_c2", rdy_w[0], 1'b0);
        chk1("t3_busy_c2", busy_w[0], 1'b1);
        rdy_seen = 1'b0;
        for (int k = 3; k <= 40; k++) begin
            @(negedge clk);
            if (rdy_w[0] !== 1'b0) rdy_seen = 1'b1;
            if (k == 40) chk1("t3_stop_c40", tx_w[0], 1'b1);
        end
        chk1("t3_ready_held_low", rdy_seen, 1'b0);
        @(negedge clk);
        chk1("t3_second_start_no_gap", tx_w[0], 1'b0);
        chk1("t3_ready_after_start", rdy_w[0], 1'b1);
        wait_idle(0, "t3");

        // ena dropped mid-frame with a byte held.
        @(negedge clk);
        valid_a[0] = 1'b1;
        data_a[0]  = 8'h11;
        exp_q.push_back('{0, 8'h11, 1'b0});
        @(posedge clk);
        #1 data_a[0] = 8'h22;
        exp_q.push_back('{0, 8'h22, 1'b0});
        @(posedge clk);
        #1 valid_a[0] = 1'b0;
        cyc(8);
        ena_a[0] = 1'b0;
        rdy_seen = 1'b0;
        for (int n = 0; n < 200 && busy_w[0] !== 1'b0; n++) begin
            @(negedge clk);
            if (rdy_w[0] !== 1'b0) rdy_seen = 1'b1;
        end
        chk1("t4_ready_low_while_disabled", rdy_seen, 1'b0);
        chk1("t4_both_frames_done", busy_w[0], 1'b0);
        valid_a[0] = 1'b1;
        data_a[0]  = 8'h33;
        bad_seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b0 || busy_w[0] !== 1'b0) bad_seen = 1'b1;
        end
        chk1("t4_no_accept_while_disabled", bad_seen, 1'b0);
        ena_a[0] = 1'b1;
        send(0, 8'h33, 1'b0);
        check_frame(0, 8'h33, 4, 0, 1'b0, 1, "t4_third");

        // Reset pulse during data bit 3, then a clean frame.
        send(0, 8'hC3, 1'b0);
        cyc(18);
        #1 rst_a[0] = 1'b0;
        #1;
        chk1("t5_async_tx", tx_w[0], 1'b1);
        chk1("t5_async_busy", busy_w[0], 1'b0);
        chk1("t5_async_ready", rdy_w[0], 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_a[0] = 1'b1;
        @(negedge clk);
        chk1("t5_ready_before_edge", rdy_w[0], 1'b0);
        @(negedge clk);
        chk1("t5_ready_first_edge", rdy_w[0], 1'b1);
        send(0, 8'h3C, 1'b0);
        check_frame(0, 8'h3C, 4, 0, 1'b0, 1, "t5_3c");

        // Two stop bits, CLKS_PER_BIT=2: 0xFF in 22 cycles.
        send(3, 8'hFF, 1'b0);
        check_frame(3, 8'hFF, 2, 0, 1'b0, 2, "t6_ff");

        cyc(5);
        chk8("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
